nou_dsa_fifo_bridge: RTL and testbench

Buffering stage between the DSA command/response channels and the NoU core. It holds two synchronous FIFOs:
- Command FIFO: DSA pushes, NoU pops through an empty/rd_en interface. Read data is registered and arrives one cycle after rd_en (the NoU f0/f1 timing).
- Response FIFO: NoU pushes through a full/wr_en interface, DSA pops as first-word-fall-through with valid/ready.

It also reports occupancy and sticky protocol-error flags to the control/status path.

---
 rtl/nou_dsa_fifo_bridge_pkg.sv | 18 +
 rtl/nou_dsa_fifo_bridge_sync_fifo.sv | 80 ++++++++
 rtl/nou_dsa_fifo_bridge.sv | 116 +++++++++++
 tb/tb_nou_dsa_fifo_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nou_dsa_fifo_bridge_pkg.sv
// NoU <-> DSA FIFO bridge shared definitions.
// Word width, default depths and sizing helpers.
`ifndef NOU_XOCC_CMD_WIDTH
`define NOU_XOCC_CMD_WIDTH 32
`endif

package nou_dsa_fifo_bridge_pkg;

  localparam int NOU_CMD_W = `NOU_XOCC_CMD_WIDTH;
  localparam int NOU_CMD_DEPTH = 16;
  localparam int NOU_RSP_DEPTH = 16;
  localparam int NOU_CMD_AFULL_TH = 12;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/nou_dsa_fifo_bridge_sync_fifo.sv
// Single-clock FIFO, registered-read or FWFT.
// Flags are registered from next-state count.
module nou_sync_fifo
  import nou_dsa_fifo_bridge_pkg::*;
#(
  parameter int WIDTH = NOU_CMD_W,
  parameter int DEPTH = 16,
  parameter bit RD_REG = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             udf,
  output logic             ovf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_nxt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  assign ovf   = wr_en & full;
  assign udf   = rd_en & empty;

  assign cnt_nxt = count
                 + CW'(do_wr)
                 - CW'(do_rd);

  // Pointers, occupancy and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == CW'(DEPTH));
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

  if (RD_REG) begin : g_reg
    logic [WIDTH-1:0] q;

    // Popped word held until next pop
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (do_rd) begin
        q <= mem[rptr];
      end
    end

    assign rd_data = q;
  end else begin : g_fwft
    assign rd_data = mem[rptr];
  end

endmodule

// File: rtl/nou_dsa_fifo_bridge.sv
// DSA command/response buffering for NoU core.
// Adds handshakes, almost-full and sticky errors.
module nou_dsa_fifo_bridge
  import nou_dsa_fifo_bridge_pkg::*;
#(
  parameter int CMD_WIDTH = `NOU_XOCC_CMD_WIDTH,
  parameter int CMD_DEPTH = NOU_CMD_DEPTH,
  parameter int RSP_DEPTH = NOU_RSP_DEPTH,
  parameter int CMD_AFULL_TH = NOU_CMD_AFULL_TH,
  localparam int CCW = $clog2(CMD_DEPTH + 1),
  localparam int RCW = $clog2(RSP_DEPTH + 1)
) (
  input  logic                 nou_clk,
  input  logic                 nou_rstn,
  input  logic                 dsa_cmd_vld,
  output logic                 dsa_cmd_rdy,
  input  logic [CMD_WIDTH-1:0] dsa_cmd_data,
  output logic                 nou_cmd_fifo_empty,
  input  logic                 nou_cmd_fifo_rd_en,
  output logic [CMD_WIDTH-1:0] nou_cmd_fifo_data,
  output logic                 nou_rsp_fifo_full,
  input  logic                 nou_rsp_fifo_wr_en,
  input  logic [CMD_WIDTH-1:0] nou_rsp_fifo_data,
  output logic                 dsa_rsp_vld,
  input  logic                 dsa_rsp_rdy,
  output logic [CMD_WIDTH-1:0] dsa_rsp_data,
  output logic [CCW-1:0]       cmd_cnt,
  output logic [RCW-1:0]       rsp_cnt,
  output logic                 cmd_afull,
  input  logic                 err_clr,
  output logic                 err_udf,
  output logic                 err_ovf
);

  logic           cmd_full;
  logic           cmd_push;
  logic           cmd_pop;
  logic           cmd_udf;
  logic           cmd_ovf;
  logic [CCW-1:0] cmd_cnt_nxt;
  logic           rsp_empty;
  logic           rsp_pop;
  logic           rsp_udf;
  logic           rsp_ovf;

  assign dsa_cmd_rdy = ~cmd_full;
  assign cmd_push = dsa_cmd_vld & dsa_cmd_rdy;
  assign cmd_pop = nou_cmd_fifo_rd_en
                 & ~nou_cmd_fifo_empty;

  assign cmd_cnt_nxt = cmd_cnt
                     + CCW'(cmd_push)
                     - CCW'(cmd_pop);

  assign dsa_rsp_vld = ~rsp_empty;
  assign rsp_pop = dsa_rsp_vld & dsa_rsp_rdy;

  nou_sync_fifo #(
    .WIDTH  (CMD_WIDTH),
    .DEPTH  (CMD_DEPTH),
    .RD_REG (1'b1)
  ) u_cmd_fifo (
    .clk     (nou_clk),
    .rst_n   (nou_rstn),
    .wr_en   (cmd_push),
    .wr_data (dsa_cmd_data),
    .rd_en   (nou_cmd_fifo_rd_en),
    .rd_data (nou_cmd_fifo_data),
    .empty   (nou_cmd_fifo_empty),
    .full    (cmd_full),
    .count   (cmd_cnt),
    .udf     (cmd_udf),
    .ovf     (cmd_ovf)
  );

  nou_sync_fifo #(
    .WIDTH  (CMD_WIDTH),
    .DEPTH  (RSP_DEPTH),
    .RD_REG (1'b0)
  ) u_rsp_fifo (
    .clk     (nou_clk),
    .rst_n   (nou_rstn),
    .wr_en   (nou_rsp_fifo_wr_en),
    .wr_data (nou_rsp_fifo_data),
    .rd_en   (rsp_pop),
    .rd_data (dsa_rsp_data),
    .empty   (rsp_empty),
    .full    (nou_rsp_fifo_full),
    .count   (rsp_cnt),
    .udf     (rsp_udf),
    .ovf     (rsp_ovf)
  );

  // Almost-full tracks next-state occupancy
  always_ff @(posedge nou_clk or negedge nou_rstn) begin
    if (!nou_rstn) begin
      cmd_afull <= 1'b0;
    end else begin
      cmd_afull <= (cmd_cnt_nxt >= CCW'(CMD_AFULL_TH));
    end
  end

  // Sticky error flags, a new event beats clear
  always_ff @(posedge nou_clk or negedge nou_rstn) begin
    if (!nou_rstn) begin
      err_udf <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_udf <= cmd_udf | rsp_udf
               | (err_udf & ~err_clr);
      err_ovf <= rsp_ovf | cmd_ovf
               | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_nou_dsa_fifo_bridge.sv
// Scoreboard bench for nou_dsa_fifo_bridge.
// Directed scenarios followed by random traffic.
module tb_nou_dsa_fifo_bridge;

  localparam int W  = 32;
  localparam int D  = 16;
  localparam int TH = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_vld, cmd_rdy;
  logic [W-1:0] cmd_data;
  logic         cmd_empty, cmd_rd;
  logic [W-1:0] cmd_q;
  logic         rsp_full, rsp_wr;
  logic [W-1:0] rsp_wdata;
  logic         rsp_vld, rsp_rdy;
  logic [W-1:0] rsp_q;
  logic [4:0]   cmd_cnt, rsp_cnt;
  logic         afull, clr, e_udf, e_ovf;

  int total = 0;
  int bad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] rq[$];
  logic [W-1:0] exp_cmd[$];
  logic [W-1:0] held = '0;
  logic [W-1:0] tmp;
  bit           m_udf = 1'b0;
  bit           m_ovf = 1'b0;
  int           cs, rs;

  always #5 clk = ~clk;

  nou_dsa_fifo_bridge dut (
    .nou_clk            (clk),
    .nou_rstn           (rst_n),
    .dsa_cmd_vld        (cmd_vld),
    .dsa_cmd_rdy        (cmd_rdy),
    .dsa_cmd_data       (cmd_data),
    .nou_cmd_fifo_empty (cmd_empty),
    .nou_cmd_fifo_rd_en (cmd_rd),
    .nou_cmd_fifo_data  (cmd_q),
    .nou_rsp_fifo_full  (rsp_full),
    .nou_rsp_fifo_wr_en (rsp_wr),
    .nou_rsp_fifo_data  (rsp_wdata),
    .dsa_rsp_vld        (rsp_vld),
    .dsa_rsp_rdy        (rsp_rdy),
    .dsa_rsp_data       (rsp_q),
    .cmd_cnt            (cmd_cnt),
    .rsp_cnt            (rsp_cnt),
    .cmd_afull          (afull),
    .err_clr            (clr),
    .err_udf            (e_udf),
    .err_ovf            (e_ovf)
  );

  task automatic chk(input string nm,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: queues updated at each edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) begin
        cs = mq.size();
        rs = rq.size();
        if (cmd_rd && cs > 0) begin
          tmp = mq.pop_front();
          exp_cmd.push_back(tmp);
        end
        if (cmd_vld && cs < D) mq.push_back(cmd_data);
        m_udf = (cmd_rd && cs == 0) || (m_udf && !clr);
        if (rsp_rdy && rs > 0) tmp = rq.pop_front();
        if (rsp_wr && rs < D) rq.push_back(rsp_wdata);
        m_ovf = (rsp_wr && rs == D) || (m_ovf && !clr);
      end
    end
  end

  // Monitor: compare DUT against model mid-cycle
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_cmd.size() > 0) held = exp_cmd.pop_front();
      chk("cmd_data", cmd_q, held);
      chk("cmd_empty", cmd_empty, mq.size() == 0);
      chk("cmd_rdy", cmd_rdy, mq.size() < D);
      chk("cmd_cnt", cmd_cnt, mq.size());
      chk("cmd_afull", afull, mq.size() >= TH);
      chk("rsp_full", rsp_full, rq.size() == D);
      chk("rsp_vld", rsp_vld, rq.size() > 0);
      chk("rsp_cnt", rsp_cnt, rq.size());
      chk("err_udf", e_udf, m_udf);
      chk("err_ovf", e_ovf, m_ovf);
      if (rq.size() > 0) chk("rsp_data", rsp_q, rq[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_vld = 1'b0;
    cmd_rd = 1'b0;
    rsp_wr = 1'b0;
    rsp_rdy = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    mq.delete();
    rq.delete();
    exp_cmd.delete();
    held = '0;
    m_udf = 1'b0;
    m_ovf = 1'b0;
    #1;
    chk("rst_async_cnt", cmd_cnt, 0);
    chk("rst_async_empty", cmd_empty, 1);
    chk("rst_async_rdy", cmd_rdy, 1);
    chk("rst_async_data", cmd_q, 0);
    chk("rst_async_rvld", rsp_vld, 0);
    chk("rst_async_rcnt", rsp_cnt, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  task automatic single_cmd(input logic [W-1:0] v);
    cmd_vld = 1'b1;
    cmd_data = v;
    cyc();
    cmd_vld = 1'b0;
    cmd_rd = 1'b1;
    cyc();
    cmd_rd = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    idle();
    cmd_data = '0;
    rsp_wdata = '0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    single_cmd(32'hA5);

    for (int i = 0; i < 17; i++) begin
      cmd_vld = 1'b1;
      cmd_data = i;
      cyc();
    end
    cmd_vld = 1'b0;
    cmd_rd = 1'b1;
    repeat (17) cyc();
    cmd_rd = 1'b0;
    cyc();

    for (int i = 0; i < 8; i++) begin
      cmd_vld = 1'b1;
      cmd_data = $urandom;
      cyc();
    end
    cmd_rd = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cmd_data = $urandom;
      cyc();
    end
    cmd_vld = 1'b0;
    repeat (9) cyc();
    cmd_rd = 1'b0;
    cyc();

    cmd_rd = 1'b1;
    cyc();
    cmd_rd = 1'b0;
    cyc();
    clr = 1'b1;
    cyc();
    cmd_rd = 1'b1;
    cyc();
    idle();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    rsp_wr = 1'b1;
    rsp_wdata = 32'h11;
    cyc();
    rsp_wdata = 32'h22;
    cyc();
    rsp_wr = 1'b0;
    repeat (3) cyc();
    rsp_rdy = 1'b1;
    repeat (3) cyc();
    rsp_rdy = 1'b0;
    rsp_wr = 1'b1;
    for (int i = 0; i < 17; i++) begin
      rsp_wdata = 32'h100 + i;
      cyc();
    end
    rsp_wr = 1'b0;
    cyc();
    rsp_wr = 1'b1;
    rsp_rdy = 1'b1;
    rsp_wdata = 32'hBEEF;
    cyc();
    rsp_wr = 1'b0;
    repeat (18) cyc();
    idle();
    clr = 1'b1;
    cyc();
    clr = 1'b0;

    for (int i = 0; i < 5; i++) begin
      cmd_vld = 1'b1;
      cmd_data = 32'h50 + i;
      rsp_wr = 1'b1;
      rsp_wdata = 32'h60 + i;
      cyc();
    end
    do_reset();
    cyc();
    single_cmd(32'hA5);

    for (int i = 0; i < 2000; i++) begin
      cmd_vld = 1'($urandom_range(0, 1));
      cmd_data = $urandom;
      cmd_rd = ($urandom_range(0, 2) == 0);
      rsp_wr = 1'($urandom_range(0, 1));
      rsp_wdata = $urandom;
      rsp_rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
